// File: rtl/jk_bank_driver.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : jk_bank_driver                                                  |
// | Purpose  : Drives a JK flip-flop bank to a requested word using set/reset  |
// |            excitation only, then verifies the settled bank against target. |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module jk_bank_driver #(
   parameter int WIDTH  = 4,
   parameter int SETTLE = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             tgt_valid,
   input  logic [WIDTH-1:0] tgt,
   output logic             tgt_ready,
   input  logic [WIDTH-1:0] q_in,
   output logic [WIDTH-1:0] j_out,
   output logic [WIDTH-1:0] k_out,
   output logic             en_out,
   output logic             done,
   output logic             mismatch,
   output logic [WIDTH-1:0] changed
);

   localparam int               C_CNT_W    = (SETTLE > 1) ? $clog2(SETTLE) : 1;
   localparam logic [C_CNT_W-1:0] C_CNT_LOAD = C_CNT_W'(SETTLE - 1);
   localparam logic [C_CNT_W-1:0] C_CNT_ONE  = C_CNT_W'(1);
   localparam logic [C_CNT_W-1:0] C_CNT_ZERO = '0;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DRIVE  = 2'd1,
      ST_SETTLE = 2'd2,
      ST_CHECK  = 2'd3
   } state_t;

   state_t               r_state;
   state_t               w_next;
   logic [C_CNT_W-1:0]   r_cnt;
   logic [WIDTH-1:0]     r_tgt;
   logic [WIDTH-1:0]     r_j;
   logic [WIDTH-1:0]     r_k;
   logic                 r_en;
   logic                 r_done;
   logic                 r_mismatch;
   logic [WIDTH-1:0]     r_changed;
   logic                 w_accept;
   logic [WIDTH-1:0]     w_diff;

   // Ready is masked during reset so nothing is accepted on a reset edge.
   assign tgt_ready = (r_state == ST_IDLE) && !reset;
   assign w_accept  = tgt_valid && tgt_ready;
   assign w_diff    = tgt ^ q_in;

   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE:   if (w_accept) w_next = (|w_diff) ? ST_DRIVE : ST_CHECK;
         ST_DRIVE:  w_next = ST_SETTLE;
         ST_SETTLE: if (r_cnt == C_CNT_ZERO) w_next = ST_CHECK;
         ST_CHECK:  w_next = ST_IDLE;
         default:   w_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) r_state <= ST_IDLE;
      else       r_state <= w_next;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_cnt      <= C_CNT_ZERO;
         r_tgt      <= '0;
         r_j        <= '0;
         r_k        <= '0;
         r_en       <= 1'b0;
         r_done     <= 1'b0;
         r_mismatch <= 1'b0;
         r_changed  <= '0;
      end else begin
         r_j    <= '0;
         r_k    <= '0;
         r_en   <= 1'b0;
         r_done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  r_tgt      <= tgt;
                  r_changed  <= w_diff;
                  r_mismatch <= 1'b0;
                  // Set-only / reset-only excitation: J and K are disjoint by construction.
                  r_j        <= ~q_in & tgt;
                  r_k        <= q_in & ~tgt;
                  r_en       <= |w_diff;
                  // Nothing to change: the check happens in the very next cycle.
                  r_done     <= ~(|w_diff);
               end
            end
            ST_DRIVE: r_cnt <= C_CNT_LOAD;
            ST_SETTLE: begin
               if (r_cnt == C_CNT_ZERO) begin
                  r_done     <= 1'b1;
                  r_mismatch <= (q_in != r_tgt);
               end else begin
                  r_cnt <= r_cnt - C_CNT_ONE;
               end
            end
            default: ;
         endcase
      end
   end

   assign j_out    = r_j;
   assign k_out    = r_k;
   assign en_out   = r_en;
   assign done     = r_done;
   assign mismatch = r_mismatch;
   assign changed  = r_changed;

endmodule
`default_nettype wire

// File: doc/jk_bank_driver.md
# jk_bank_driver

Controller that drives a bank of WIDTH JK flip-flops, each with J, K and enable inputs, so the bank reaches a requested target word. It accepts a target over a valid/ready handshake and samples the bank's Q feedback. From those it computes minimal JK excitation that never uses toggle, pulses the shared enable for one cycle, waits for the bank to settle, then checks the result. It sits between the sequencing logic and the JK register bank.

## Interface
- WIDTH, 4: number of JK flip-flops in the bank.
- SETTLE, 2: cycles to wait after the enable pulse before checking; legal range ≥1.

Ports:
- CLK  in  1  rising-edge clock.
- RESET  in  1  synchronous, active-high reset.
- TGT_VALID  in  1  target word available.
- TGT  in  WIDTH  requested bank value.
- TGT_READY  out  1  high in IDLE; a target is accepted when TGT_VALID && TGT_READY on a rising edge.
- Q_IN  in  WIDTH  feedback from the JK bank Q outputs.
- J_OUT  out  WIDTH  registered J drive.
- K_OUT  out  WIDTH  registered K drive.
- EN_OUT  out  1  registered bank enable, one-cycle pulse.
- DONE  out  1  one-cycle pulse when a check completes.
- MISMATCH  out  1  set with DONE when Q_IN != target; holds until the next accept or reset.
- CHANGED  out  WIDTH  bits that the last accepted target needed to change (TGT ^ Q_IN at accept); holds until the next accept.

## Operation
- States: IDLE, DRIVE, SETTLE, CHECK.
- IDLE:
  - TGT_READY=1.
  - On accept, latch TGT into tgt_q and compute CHANGED = TGT ^ Q_IN.
  - Clear MISMATCH.
  - If CHANGED != 0, go to DRIVE. Otherwise go to CHECK.
- Excitation is computed at accept from the Q_IN and TGT values at that moment:
  - J = ~Q_IN & TGT.
  - K = Q_IN & ~TGT.
  - J and K are never both 1 on the same bit.
- DRIVE (exactly 1 cycle):
  - J_OUT/K_OUT hold the excitation, EN_OUT=1.
  - Go to SETTLE and load the counter with SETTLE-1.
- SETTLE:
  - J_OUT=K_OUT=0, EN_OUT=0.
  - Decrement the counter; at 0 go to CHECK.
- CHECK (1 cycle):
  - DONE=1, MISMATCH = (Q_IN != tgt_q).
  - Go to IDLE.
- TGT and TGT_VALID are ignored outside IDLE.
- RESET (any state, including mid-DRIVE or SETTLE):
  - State goes to IDLE.
  - J_OUT, K_OUT, EN_OUT, DONE, MISMATCH and CHANGED all go to 0; the counter goes to 0.
  - An aborted operation produces no DONE.
- RESET has priority over an accept on the same edge.

## Timing
- Reset values: every output is 0, except TGT_READY, which is 1 from the first cycle after RESET deasserts. TGT_READY is not asserted while RESET is high.
- Accept on edge t with CHANGED != 0:
  - EN_OUT and J/K are valid during cycle t+1.
  - SETTLE occupies cycles t+2 … t+1+SETTLE.
  - DONE is high in cycle t+2+SETTLE.
  - TGT_READY is high again in cycle t+3+SETTLE.
- Accept with CHANGED == 0:
  - No EN_OUT pulse.
  - DONE is high in cycle t+1.
  - TGT_READY is high in cycle t+2.
- With TGT_VALID held high, back-to-back targets are accepted on the first IDLE cycle after each DONE.
- MISMATCH and CHANGED update in the same cycle as DONE and the cycle after accept, respectively.

## Test plan
Bench includes a behavioural 4-bit JK bank (WIDTH=4, SETTLE=2) that updates on EN and asserts if any bit ever sees J=K=1.
- RESET held 2 cycles with TGT_VALID=1, TGT=1111 -> no accept, all outputs 0; TGT_READY=1 in the first cycle after RESET falls.
- Q=0000, TGT=1010 accepted at t -> J_OUT=1010, K_OUT=0000, EN_OUT=1 only in t+1; DONE at t+4; Q=1010; MISMATCH=0; CHANGED=1010.
- Q=1010, TGT=0110 -> J_OUT=0100, K_OUT=1000, one EN pulse, CHANGED=1100, DONE at t+4, MISMATCH=0.
- Q=0110, TGT=0110 -> no EN_OUT, DONE at t+1, CHANGED=0000, MISMATCH=0.
- Bank model with bit0 stuck at 0, TGT=0001 -> DONE at t+4 with MISMATCH=1. Next target 0000 is accepted and MISMATCH clears the cycle after accept.
- RESET pulsed during the first SETTLE cycle of TGT=1111 -> no DONE; outputs 0 the next cycle. TGT=0011 is then accepted normally with DONE 4 cycles later.
